// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Valid/ready data-memory bus between the LSU and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : RV32I load/store sequencer: lane steering, strobes, load
//               extension, stall and bus timeout. Optional macro
//               LSU_MISALIGN_TRAP_EN traps misaligned accesses instead.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         req,
    input  wire         is_store,
    input  wire  [1:0]  store_op,
    input  wire  [2:0]  load_op,
    input  wire  [31:0] addr,
    input  wire  [31:0] wdata,
    lsu_ctrl_if.master  bus,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_load_op;
    logic [1:0]       r_a;
    logic             r_bus_valid;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [3:0]       r_bus_wstrb;
    logic [31:0]      r_bus_wdata;
    logic             r_stall;
    logic             r_done;
    logic             r_err;
    logic [31:0]      r_ld_data;

    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic             w_trap;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ld_ext;

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = wdata;
        case (store_op)
            2'b00: begin
                w_wdata = {4{wdata[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{wdata[15:0]}};
                w_wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                w_wdata = wdata;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            w_wstrb = 4'b0000;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;

    always_comb begin
        w_misaligned = 1'b0;
        if (is_store) begin
            case (store_op)
                2'b00:   w_misaligned = 1'b0;
                2'b01:   w_misaligned = addr[0];
                default: w_misaligned = |addr[1:0];
            endcase
        end else begin
            case (load_op)
                3'b000, 3'b100: w_misaligned = 1'b0;
                3'b001, 3'b101: w_misaligned = addr[0];
                default:        w_misaligned = |addr[1:0];
            endcase
        end
    end

    assign w_trap = w_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    // Lane select uses the offset latched at request time, not the live addr.
    always_comb begin
        w_byte = bus.bus_rdata[7:0];
        case (r_a)
            2'd0: w_byte = bus.bus_rdata[7:0];
            2'd1: w_byte = bus.bus_rdata[15:8];
            2'd2: w_byte = bus.bus_rdata[23:16];
            2'd3: w_byte = bus.bus_rdata[31:24];
            default: w_byte = bus.bus_rdata[7:0];
        endcase
        w_half = r_a[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_load_op)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_ext = {24'h000000, w_byte};
            3'b101:  w_ld_ext = {16'h0000, w_half};
            default: w_ld_ext = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_load_op   <= 3'b000;
            r_a         <= 2'b00;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wstrb <= 4'b0000;
            r_bus_wdata <= 32'h0;
            r_stall     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ld_data   <= 32'h0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_load_op <= load_op;
                        r_a       <= addr[1:0];
                        r_cnt     <= '0;
                        r_stall   <= 1'b1;
                        if (w_trap) begin
                            // Trap cycle reuses RESP: err instead of done, stall held.
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_bus_valid <= 1'b1;
                            r_bus_we    <= is_store;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_wstrb <= w_wstrb;
                            r_bus_wdata <= w_wdata;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (bus.bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_stall     <= 1'b0;
                        r_state     <= S_RESP;
                        if (!r_bus_we) begin
                            r_ld_data <= w_ld_ext;
                        end
                    end else if (r_cnt == c_timeout_last) begin
                        r_bus_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_stall     <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_stall <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bus_valid = r_bus_valid;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wstrb = r_bus_wstrb;
    assign bus.bus_wdata = r_bus_wdata;

    // The request cycle stalls combinationally so the core holds before the FSM reacts.
    assign stall   = r_stall | ((r_state == S_IDLE) & req);
    assign done    = r_done;
    assign err     = r_err;
    assign ld_data = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed bench for lsu_ctrl with a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;
    localparam int TIMEOUT_CYC = 16;

    typedef struct packed {
        logic        is_err;
        logic        chk_ld;
        logic [31:0] ld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  store_op = 2'b00;
    logic [2:0]  load_op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] ld_data;
    logic        ready_en = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    lsu_ctrl_if bus_if ();
    assign bus_if.bus_ready = ready_en & bus_if.bus_valid;
    assign bus_if.bus_rdata = mem_rdata;

    lsu_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .is_store (is_store),
        .store_op (store_op),
        .load_op  (load_op),
        .addr     (addr),
        .wdata    (wdata),
        .bus      (bus_if),
        .stall    (stall),
        .done     (done),
        .ld_data  (ld_data),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_err", {31'b0, err}, {31'b0, mon_e.is_err});
                chk("sb_done", {31'b0, done}, {31'b0, ~mon_e.is_err});
                if (mon_e.chk_ld) begin
                    chk("sb_ld", ld_data, mon_e.ld);
                end
            end
        end
    end

    task automatic access(input logic st, input logic [1:0] sop, input logic [2:0] lop,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        exp_t e;
        @(posedge clk); #1;
        ready_en  = 1'b1;
        mem_rdata = rd;
        req = 1'b1; is_store = st; store_op = sop; load_op = lop; addr = a; wdata = wd;
        e.is_err = 1'b0; e.chk_ld = ~st; e.ld = exp_ld;
        sb.push_back(e);
        @(negedge clk);
        chk("req_stall", {31'b0, stall}, 32'd1);
        chk("req_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("bus_valid", {31'b0, bus_if.bus_valid}, 32'd1);
        chk("bus_we", {31'b0, bus_if.bus_we}, {31'b0, st});
        chk("bus_addr", bus_if.bus_addr, exp_addr);
        chk("bus_wstrb", {28'b0, bus_if.bus_wstrb}, {28'b0, exp_strb});
        if (st) chk("bus_wdata", bus_if.bus_wdata, exp_wd);
        chk("bus_stall", {31'b0, stall}, 32'd1);
        chk("bus_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_done", {31'b0, done}, 32'd1);
        chk("resp_stall", {31'b0, stall}, 32'd0);
        chk("resp_valid", {31'b0, bus_if.bus_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   nv;
        int   ne;
        int   nd;
        int   err_at;
        exp_t e;

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("rst_we", {31'b0, bus_if.bus_we}, 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'h0);
        chk("rst_wstrb", {28'b0, bus_if.bus_wstrb}, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_ld", ld_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stores: sw, sb, sh.
        access(1'b1, 2'b10, 3'b000, 32'h100, 32'hDEADBEEF, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        access(1'b1, 2'b00, 3'b000, 32'h103, 32'h000000A5, 32'h0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);

        // A req presented during RESP must not start an access.
        req = 1'b1; is_store = 1'b0; load_op = 3'b010; addr = 32'h600;
        chk("resp_req_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("resp_req_ignored", {31'b0, bus_if.bus_valid}, 32'd0);

        access(1'b1, 2'b01, 3'b000, 32'h102, 32'h00001234, 32'h0, 32'h100, 4'b1100, 32'h12341234, 32'h0);
        access(1'b1, 2'b00, 3'b000, 32'h101, 32'h0000005A, 32'h0, 32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0);

        // Loads with extension.
        access(1'b0, 2'b00, 3'b000, 32'h201, 32'h0, 32'h0000F000, 32'h200, 4'b0000, 32'h0, 32'hFFFFFFF0);
        access(1'b0, 2'b00, 3'b100, 32'h201, 32'h0, 32'h0000F000, 32'h200, 4'b0000, 32'h0, 32'h000000F0);
        access(1'b0, 2'b00, 3'b001, 32'h202, 32'h0, 32'h80010000, 32'h200, 4'b0000, 32'h0, 32'hFFFF8001);
        access(1'b0, 2'b00, 3'b101, 32'h202, 32'h0, 32'h80010000, 32'h200, 4'b0000, 32'h0, 32'h00008001);
        access(1'b0, 2'b00, 3'b000, 32'h203, 32'h0, 32'h7F000000, 32'h200, 4'b0000, 32'h0, 32'h0000007F);
        access(1'b0, 2'b00, 3'b010, 32'h204, 32'h0, 32'h89ABCDEF, 32'h204, 4'b0000, 32'h0, 32'h89ABCDEF);

        // Timeout: memory never answers.
        @(posedge clk); #1;
        ready_en = 1'b0;
        req = 1'b1; is_store = 1'b0; load_op = 3'b010; addr = 32'h400;
        e.is_err = 1'b1; e.chk_ld = 1'b0; e.ld = 32'h0;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b0;
        nv = 0; ne = 0; nd = 0; err_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.bus_valid) nv++;
            if (err) begin ne++; err_at = i; end
            if (done) nd++;
        end
        chk("to_valid_cycles", 32'(nv), 32'(TIMEOUT_CYC));
        chk("to_err_pulses", 32'(ne), 32'd1);
        chk("to_err_cycle", 32'(err_at), 32'(TIMEOUT_CYC));
        chk("to_done_pulses", 32'(nd), 32'd0);
        access(1'b0, 2'b00, 3'b010, 32'h404, 32'h0, 32'h11223344, 32'h404, 4'b0000, 32'h0, 32'h11223344);

        // Misaligned lw.
`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        ready_en = 1'b1; mem_rdata = 32'hCAFEF00D;
        req = 1'b1; is_store = 1'b0; load_op = 3'b010; addr = 32'h301;
        e.is_err = 1'b1; e.chk_ld = 1'b0; e.ld = 32'h0;
        sb.push_back(e);
        @(negedge clk);
        chk("trap_req_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("trap_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("trap_err", {31'b0, err}, 32'd1);
        chk("trap_stall", {31'b0, stall}, 32'd1);
        chk("trap_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_err_clear", {31'b0, err}, 32'd0);
        chk("trap_stall_clear", {31'b0, stall}, 32'd0);
        chk("trap_valid_after", {31'b0, bus_if.bus_valid}, 32'd0);
`else
        access(1'b0, 2'b00, 3'b010, 32'h301, 32'h0, 32'hCAFEF00D, 32'h300, 4'b0000, 32'h0, 32'hCAFEF00D);
`endif

        // Reset while the bus request is outstanding.
        @(posedge clk); #1;
        ready_en = 1'b0;
        req = 1'b1; is_store = 1'b1; store_op = 2'b10; addr = 32'h500; wdata = 32'h55AA55AA;
        e.is_err = 1'b0; e.chk_ld = 1'b0; e.ld = 32'h0;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("mid_valid", {31'b0, bus_if.bus_valid}, 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("mid_rst_addr", bus_if.bus_addr, 32'h0);
        chk("mid_rst_wdata", bus_if.bus_wdata, 32'h0);
        chk("mid_rst_wstrb", {28'b0, bus_if.bus_wstrb}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("post_rst_done", {31'b0, done}, 32'd0);
        access(1'b1, 2'b10, 3'b000, 32'h108, 32'h0BADF00D, 32'h0, 32'h108, 4'b1111, 32'h0BADF00D, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
